// File: rtl/sync_ram_pkg.sv
// Shared types and sizes for the two-requester RAM arbiter with fill sequencer.
package sync_ram_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on contention the requester that did not win last is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // last resets to 1 so requester 0 wins the first contended grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/sync_ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters and adds a fill sequencer.
// Optional SYNC_RAM_ARB_STATS_EN adds saturating per-requester grant counters.
module sync_ram_arbiter
    import sync_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_we_0,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_0,
    output logic [DATA_W-1:0] rsp_rdata_1,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef SYNC_RAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt_0,
    output logic [CNT_W-1:0]  grant_cnt_1
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-1:0] addr_q;
    logic              arb_en;
    logic              fill_acc;
    logic [1:0]        grant;
    req_t              req0, req1, req_sel;
    logic              rd_acc;
    logic              s1_valid;
    req_id_t           s1_id;

    assign req0    = '{we: req_we_0, addr: req_addr_0, wdata: req_wdata_0};
    assign req1    = '{we: req_we_1, addr: req_addr_1, wdata: req_wdata_1};
    assign req_sel = grant[1] ? req1 : req0;

    // fill_start wins over requests in the same cycle
    assign arb_en   = (state == IDLE) && !fill_start;
    assign fill_acc = (state == IDLE) && fill_start;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req_valid_1, req_valid_0} & {2{arb_en}}),
        .advance (arb_en),
        .grant   (grant)
    );

    assign req_ready_0 = grant[0];
    assign req_ready_1 = grant[1];
    assign rd_acc      = (grant != 2'b00) && !req_sel.we;
    assign fill_busy   = (state != IDLE);
    assign fill_done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fill_cnt <= '0;
            fill_val <= '0;
            addr_q   <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
            addr_q   <= ram_addr;
            if (fill_acc) begin
                fill_val <= fill_value;
            end
        end
    end

    // Without a grant in IDLE the address is held and the RAM performs a harmless read
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        ram_write_en = 1'b0;
        ram_addr     = addr_q;
        ram_data_in  = req_sel.wdata;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_nxt    = FILL;
                    fill_cnt_nxt = '0;
                end else if (grant != 2'b00) begin
                    ram_write_en = req_sel.we;
                    ram_addr     = req_sel.addr;
                end
            end
            FILL: begin
                ram_write_en = 1'b1;
                ram_addr     = fill_cnt;
                ram_data_in  = fill_val;
                fill_cnt_nxt = fill_cnt + 1'b1;
                if (fill_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response pipeline runs independently of the FSM so in-flight reads drain during a fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_id       <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_rdata_1 <= '0;
        end else begin
            s1_valid    <= rd_acc;
            s1_id       <= req_id_t'(grant[1]);
            rsp_valid_0 <= s1_valid && !s1_id;
            rsp_valid_1 <= s1_valid && s1_id;
            if (s1_valid && !s1_id) begin
                rsp_rdata_0 <= ram_data_out;
            end
            if (s1_valid && s1_id) begin
                rsp_rdata_1 <= ram_data_out;
            end
        end
    end

`ifdef SYNC_RAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
        end else if (fill_acc) begin
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
        end else begin
            if (grant[0] && (grant_cnt_0 != '1)) begin
                grant_cnt_0 <= grant_cnt_0 + 1'b1;
            end
            if (grant[1] && (grant_cnt_1 != '1)) begin
                grant_cnt_1 <= grant_cnt_1 + 1'b1;
            end
        end
    end
`else
    // statistics counters are not built
`endif

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: behavioural RAM, shadow-memory reference model, directed and random steps.
module tb_sync_ram_arbiter;
    import sync_ram_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        rv = '0;
    logic [1:0]        rwe = '0;
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rwd [2];
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;

    logic              req_ready_0, req_ready_1;
    logic              rsp_valid_0, rsp_valid_1;
    logic [DATA_W-1:0] rsp_rdata_0, rsp_rdata_1;
    logic              fill_busy, fill_done;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
`ifdef SYNC_RAM_ARB_STATS_EN
    logic [CNT_W-1:0]  grant_cnt_0, grant_cnt_1;
`endif

    sync_ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_0  (rv[0]),
        .req_valid_1  (rv[1]),
        .req_ready_0  (req_ready_0),
        .req_ready_1  (req_ready_1),
        .req_we_0     (rwe[0]),
        .req_we_1     (rwe[1]),
        .req_addr_0   (raddr[0]),
        .req_addr_1   (raddr[1]),
        .req_wdata_0  (rwd[0]),
        .req_wdata_1  (rwd[1]),
        .rsp_valid_0  (rsp_valid_0),
        .rsp_valid_1  (rsp_valid_1),
        .rsp_rdata_0  (rsp_rdata_0),
        .rsp_rdata_1  (rsp_rdata_1),
        .fill_start   (fill_start),
        .fill_value   (fill_value),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
`ifdef SYNC_RAM_ARB_STATS_EN
        ,
        .grant_cnt_0  (grant_cnt_0),
        .grant_cnt_1  (grant_cnt_1)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: data_out only updates on read cycles
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
        else              ram_data_out <= mem[ram_addr];
    end

    // Reference model state
    logic [DATA_W-1:0] shadow [DEPTH];
    int                m_last;
    int                m_busy;
    logic [DATA_W-1:0] m_fval;
    bit                pend_v [2][4];
    logic [DATA_W-1:0] pend_d [2][4];
    logic [DATA_W-1:0] exp_rd [2];
    int                cyc;
    bit                acc [2];
    logic [1:0]        last_ready;
    int                obs_done;
    int                rsp_cnt [2];
    int                tests = 0;
    int                fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_busy = 0;
        for (int k = 0; k < 2; k++) begin
            exp_rd[k] = '0;
            for (int j = 0; j < 4; j++) pend_v[k][j] = 1'b0;
        end
    endtask

    // One clock cycle: entered just after a falling edge with inputs already applied
    task automatic cycle();
        bit         idle;
        bit [1:0]   g;
        bit         ev;
        int         k;
        int         slot;
        #1;
        idle = (m_busy == 0);
        g = 2'b00;
        if (idle && !fill_start) begin
            if (rv == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
            else             g = rv;
        end
        last_ready = {req_ready_1, req_ready_0};
        obs_done += int'(fill_done);
        rsp_cnt[0] += int'(rsp_valid_0);
        rsp_cnt[1] += int'(rsp_valid_1);
        chk("ready_0", 64'(req_ready_0), 64'(g[0]));
        chk("ready_1", 64'(req_ready_1), 64'(g[1]));
        chk("fill_busy", 64'(fill_busy), 64'(!idle));
        chk("fill_done", 64'(fill_done), 64'(m_busy == 1));
        slot = cyc % 4;
        for (int r = 0; r < 2; r++) begin
            ev = pend_v[r][slot];
            if (ev) begin
                exp_rd[r] = pend_d[r][slot];
                pend_v[r][slot] = 1'b0;
            end
            if (r == 0) begin
                chk("rsp_valid_0", 64'(rsp_valid_0), 64'(ev));
                chk("rsp_rdata_0", 64'(rsp_rdata_0), 64'(exp_rd[0]));
            end else begin
                chk("rsp_valid_1", 64'(rsp_valid_1), 64'(ev));
                chk("rsp_rdata_1", 64'(rsp_rdata_1), 64'(exp_rd[1]));
            end
        end
        if (m_busy > 1) begin
            chk("fill_we", 64'(ram_write_en), 64'(1));
            chk("fill_addr", 64'(ram_addr), 64'(DEPTH + 1 - m_busy));
            chk("fill_data", 64'(ram_data_in), 64'(m_fval));
        end else if (g != 2'b00) begin
            k = int'(g[1]);
            chk("ram_we", 64'(ram_write_en), 64'(rwe[k]));
            chk("ram_addr", 64'(ram_addr), 64'(raddr[k]));
            if (rwe[k]) chk("ram_wdata", 64'(ram_data_in), 64'(rwd[k]));
        end else begin
            chk("ram_we_idle", 64'(ram_write_en), 64'(0));
        end
        // advance the model across the coming rising edge
        if (m_busy > 0) begin
            if (m_busy > 1) shadow[DEPTH + 1 - m_busy] = m_fval;
            m_busy--;
        end else if (fill_start) begin
            m_busy = DEPTH + 1;
            m_fval = fill_value;
        end else if (g != 2'b00) begin
            k = int'(g[1]);
            m_last = k;
            if (rwe[k]) begin
                shadow[raddr[k]] = rwd[k];
            end else begin
                pend_v[k][(cyc + 2) % 4] = 1'b1;
                pend_d[k][(cyc + 2) % 4] = shadow[raddr[k]];
            end
        end
        acc[0] = g[0];
        acc[1] = g[1];
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int k, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rv[k] = 1'b1; rwe[k] = we; raddr[k] = a; rwd[k] = d;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (acc[k]) break;
        end
        chk("issue_accepted", 64'(acc[k]), 64'(1));
        rv[k] = 1'b0;
    endtask

    task automatic wait_fill_idle();
        for (int i = 0; i < 400 && m_busy != 0; i++) cycle();
        chk("fill_finished", 64'(m_busy), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        int d0;
        int c0, c1;
        raddr[0] = '0; raddr[1] = '0; rwd[0] = '0; rwd[1] = '0;
        obs_done = 0; rsp_cnt[0] = 0; rsp_cnt[1] = 0; cyc = 0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 64'(fill_busy), 64'(0));
        chk("rst_done", 64'(fill_done), 64'(0));
        chk("rst_rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
        chk("rst_rdata_0", 64'(rsp_rdata_0), 64'(0));
        chk("rst_we", 64'(ram_write_en), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // write then read back from requester 0
        issue(0, 1'b1, 8'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 8'h10, '0);
        cycle(); cycle();
        chk("t1_rdata", 64'(rsp_rdata_0), 64'(32'hDEADBEEF));
        cycle();

        // contended reads alternate starting with requester 0
        issue(0, 1'b1, 8'h01, 32'h1111_1111);
        issue(1, 1'b1, 8'h02, 32'h2222_2222);
        c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
        rv = 2'b11; rwe = 2'b00; raddr[0] = 8'h01; raddr[1] = 8'h02;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t2_grant_order", 64'(last_ready), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        rv = 2'b00;
        repeat (3) cycle();
        chk("t2_rsp_cnt_0", 64'(rsp_cnt[0] - c0), 64'(3));
        chk("t2_rsp_cnt_1", 64'(rsp_cnt[1] - c1), 64'(3));

        // fill while requester 1 waits
        rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 8'h55;
        fill_start = 1'b1; fill_value = 32'hA5A5A5A5;
        d0 = obs_done;
        cycle();
        fill_start = 1'b0;
        nr = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (last_ready[1]) break;
            nr++;
        end
        rv[1] = 1'b0;
        chk("t3_not_ready_cycles", 64'(nr), 64'(257));
        chk("t3_done_pulses", 64'(obs_done - d0), 64'(1));
        issue(0, 1'b0, 8'h00, '0);
        issue(0, 1'b0, 8'h7F, '0);
        issue(0, 1'b0, 8'hFF, '0);
        cycle(); cycle();
        chk("t3_fill_data", 64'(rsp_rdata_0), 64'(32'hA5A5A5A5));
        chk("t3_r1_data", 64'(rsp_rdata_1), 64'(32'hA5A5A5A5));

        // read accepted the cycle before a fill keeps its pre-fill data
        issue(0, 1'b1, 8'h20, 32'h12345678);
        issue(0, 1'b0, 8'h20, '0);
        fill_start = 1'b1; fill_value = 32'h0;
        cycle();
        fill_start = 1'b0;
        cycle();
        chk("t4_rdata", 64'(rsp_rdata_0), 64'(32'h12345678));
        wait_fill_idle();

        // randomized traffic with occasional fill requests
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rv[k] && $urandom_range(2) != 0) begin
                    rv[k] = 1'b1;
                    rwe[k] = 1'($urandom_range(1));
                    raddr[k] = 8'($urandom_range(15));
                    rwd[k] = $urandom;
                end
            end
            fill_start = ($urandom_range(199) == 0);
            fill_value = $urandom;
            cycle();
            for (int k = 0; k < 2; k++) if (acc[k]) rv[k] = 1'b0;
        end
        fill_start = 1'b0;
        for (int i = 0; i < 600 && rv != 2'b00; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) if (acc[k]) rv[k] = 1'b0;
        end
        chk("t5_drained", 64'(rv), 64'(0));
        wait_fill_idle();
        repeat (3) cycle();

        // asynchronous reset in the middle of a fill
        fill_start = 1'b1; fill_value = 32'h0F0F0F0F;
        cycle();
        fill_start = 1'b0;
        repeat (50) cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(fill_busy), 64'(0));
        chk("t6_done", 64'(fill_done), 64'(0));
        chk("t6_rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
        chk("t6_we", 64'(ram_write_en), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = obs_done;
        repeat (300) cycle();
        chk("t6_no_done", 64'(obs_done - d0), 64'(0));

        // reset drops an in-flight read response
        c0 = rsp_cnt[0];
        issue(0, 1'b0, 8'h03, '0);
        rst_n = 1'b0;
        #1;
        chk("t6_rd_rsp_valid", 64'(rsp_valid_0), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("t6_rsp_dropped", 64'(rsp_cnt[0] - c0), 64'(0));
        rv = 2'b11; rwe = 2'b00; raddr[0] = 8'h04; raddr[1] = 8'h05;
        cycle();
        chk("t6_first_grant", 64'(last_ready), 64'(2'b01));
        rv = 2'b00;
        repeat (3) cycle();

`ifdef SYNC_RAM_ARB_STATS_EN
        rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 8'h04;
        repeat (70000) cycle();
        rv[0] = 1'b0;
        cycle();
        chk("stats_saturated", 64'(grant_cnt_0), 64'(16'hFFFF));
        fill_start = 1'b1; fill_value = 32'h5A5A5A5A;
        cycle();
        fill_start = 1'b0;
        cycle();
        chk("stats_cleared", 64'(grant_cnt_0), 64'(0));
        wait_fill_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
